// File: rtl/c64_bus_decoder.sv
// c64_bus_decoder
// Memory-map decoder and 6510 on-chip port for the C64 (no cartridge).
// Steers each core access to RAM, BASIC/KERNAL/char ROM or the I/O window,
// muxes the read data back to the core, and holds the $0000/$0001 port
// registers whose LORAM/HIRAM/CHAREN bits choose the bank configuration.
// An open-bus latch supplies data for reads of the unmapped $DE00-$DFFF range.

module c64_bus_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ab,
    input  logic        we,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        basic_cs,
    output logic        kernal_cs,
    output logic        char_cs,
    input  logic [7:0]  basic_rdata,
    input  logic [7:0]  kernal_rdata,
    input  logic [7:0]  char_rdata,
    output logic        io_cs,
    output logic        io_we,
    input  logic [7:0]  io_rdata,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out,
    output logic [7:0]  port_dir
);

    logic [7:0] ddr;
    logic [7:0] pdata;
    logic [7:0] bus_last;
    logic [7:0] eff;

    logic loram;
    logic hiram;
    logic charen;

    logic in_basic_win;
    logic in_d_win;
    logic in_kernal_win;
    logic in_open_bus_win;

    logic basic_map;
    logic kernal_map;
    logic char_map;
    logic io_map;
    logic open_bus;
    logic ddr_addr;
    logic pdata_addr;

    // Input pins drive the bits the DDR leaves as inputs; the register drives the rest
    assign eff    = (pdata & ddr) | (port_in & ~ddr);
    assign loram  = eff[0];
    assign hiram  = eff[1];
    assign charen = eff[2];

    assign port_out = pdata;
    assign port_dir = ddr;

    // Fixed address windows; the bank bits then decide what lives in them
    always_comb begin
        in_basic_win    = (ab[15:13] == 3'b101);
        in_d_win        = (ab[15:12] == 4'hD);
        in_kernal_win   = (ab[15:13] == 3'b111);
        in_open_bus_win = (ab[11:9] == 3'b111);
        ddr_addr        = (ab == 16'h0000);
        pdata_addr      = (ab == 16'h0001);

        basic_map  = in_basic_win & loram & hiram;
        kernal_map = in_kernal_win & hiram;
        io_map     = in_d_win & (loram | hiram) & charen;
        char_map   = in_d_win & (loram | hiram) & ~charen;
        open_bus   = io_map & in_open_bus_win;
    end

    // Chip selects and write strobes; ROMs are read-only so writes fall through to RAM
    always_comb begin
        basic_cs  = basic_map & ~we;
        kernal_cs = kernal_map & ~we;
        char_cs   = char_map & ~we;
        io_cs     = io_map & ~open_bus;
        io_we     = we & io_map & ~open_bus;
        ram_we    = we & ~io_map;
        ram_wdata = cpu_do;
    end

    // Read-data mux back to the core; port registers take priority over RAM
    always_comb begin
        cpu_di = ram_rdata;
        if (ddr_addr) begin
            cpu_di = ddr;
        end else if (pdata_addr) begin
            cpu_di = eff;
        end else if (open_bus) begin
            cpu_di = bus_last;
        end else if (io_map) begin
            cpu_di = io_rdata;
        end else if (char_map) begin
            cpu_di = char_rdata;
        end else if (basic_map) begin
            cpu_di = basic_rdata;
        end else if (kernal_map) begin
            cpu_di = kernal_rdata;
        end
    end

    // Port registers load on writes to $0000/$0001; the open-bus latch tracks the
    // last value seen on the data bus, except when it was itself the source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ddr      <= 8'h00;
            pdata    <= 8'h00;
            bus_last <= 8'h00;
        end else begin
            if (we && ddr_addr) begin
                ddr <= cpu_do;
            end
            if (we && pdata_addr) begin
                pdata <= cpu_do;
            end
            if (we) begin
                bus_last <= cpu_do;
            end else if (!open_bus) begin
                bus_last <= cpu_di;
            end
        end
    end

endmodule

// File: tb/tb_c64_bus_decoder.sv
// tb_c64_bus_decoder
// Directed bench for the C64 bus decoder. Each step drives one access, pushes
// the expected {port_dir, port_out, cpu_di, selects} into a scoreboard queue and
// pops it when the outputs are sampled on the falling edge.

module tb_c64_bus_decoder;

    logic        clk;
    logic        reset;
    logic [15:0] ab;
    logic        we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        basic_cs;
    logic        kernal_cs;
    logic        char_cs;
    logic [7:0]  basic_rdata;
    logic [7:0]  kernal_rdata;
    logic [7:0]  char_rdata;
    logic        io_cs;
    logic        io_we;
    logic [7:0]  io_rdata;
    logic [7:0]  port_in;
    logic [7:0]  port_out;
    logic [7:0]  port_dir;

    logic [7:0]  ram_mem [0:65535];

    logic [29:0] exp_q [$];
    string       tag_q [$];
    int          test_count;
    int          fail_count;

    // Select vector order: {ram_we, basic_cs, kernal_cs, char_cs, io_cs, io_we}
    localparam logic [5:0] SEL_NONE   = 6'b000000;
    localparam logic [5:0] SEL_RAMWE  = 6'b100000;
    localparam logic [5:0] SEL_BASIC  = 6'b010000;
    localparam logic [5:0] SEL_KERNAL = 6'b001000;
    localparam logic [5:0] SEL_CHAR   = 6'b000100;
    localparam logic [5:0] SEL_IO     = 6'b000010;
    localparam logic [5:0] SEL_IOWE   = 6'b000011;

    c64_bus_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .ab           (ab),
        .we           (we),
        .cpu_do       (cpu_do),
        .cpu_di       (cpu_di),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .basic_cs     (basic_cs),
        .kernal_cs    (kernal_cs),
        .char_cs      (char_cs),
        .basic_rdata  (basic_rdata),
        .kernal_rdata (kernal_rdata),
        .char_rdata   (char_rdata),
        .io_cs        (io_cs),
        .io_we        (io_we),
        .io_rdata     (io_rdata),
        .port_in      (port_in),
        .port_out     (port_out),
        .port_dir     (port_dir)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: asynchronous read, write on the rising edge
    assign ram_rdata = ram_mem[ab];
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ab] <= ram_wdata;
        end
    end

    function automatic logic [29:0] expVec(input logic [7:0] dir, input logic [7:0] pout,
                                           input logic [7:0] di, input logic [5:0] sel);
        return {dir, pout, di, sel};
    endfunction

    // Pop the oldest expectation and compare it with the current outputs
    task automatic checkOutput();
        logic [29:0] expected;
        logic [29:0] observed;
        string       tag;
        expected = exp_q.pop_front();
        tag      = tag_q.pop_front();
        observed = {port_dir, port_out, cpu_di,
                    ram_we, basic_cs, kernal_cs, char_cs, io_cs, io_we};
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed dir/out/di/sel=%h/%h/%h/%b expected %h/%h/%h/%b",
                   tag, observed[29:22], observed[21:14], observed[13:6], observed[5:0],
                   expected[29:22], expected[21:14], expected[13:6], expected[5:0]);
        end
    endtask

    // Drive one access just after the rising edge, record its expectation, check on the falling edge
    task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [7:0] data,
                                 input logic [29:0] expected, input string tag);
        @(posedge clk);
        #1;
        ab     = addr;
        we     = wr;
        cpu_do = data;
        exp_q.push_back(expected);
        tag_q.push_back(tag);
        @(negedge clk);
        checkOutput();
    endtask

    // Directed sequence walking through bank switching, write-through and open bus
    initial begin
        test_count   = 0;
        fail_count   = 0;
        reset        = 1'b0;
        ab           = 16'h0000;
        we           = 1'b0;
        cpu_do       = 8'h00;
        port_in      = 8'hFF;
        basic_rdata  = 8'h22;
        kernal_rdata = 8'h33;
        char_rdata   = 8'h44;
        io_rdata     = 8'h55;
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = 8'h11;
        end

        applyStimulus(16'h0001, 1'b0, 8'h00, expVec(8'h00, 8'h00, 8'hFF, SEL_NONE), "reset_eff");
        reset = 1'b1;

        applyStimulus(16'hA000, 1'b0, 8'h00, expVec(8'h00, 8'h00, 8'h22, SEL_BASIC),  "std_basic");
        applyStimulus(16'hD000, 1'b0, 8'h00, expVec(8'h00, 8'h00, 8'h55, SEL_IO),     "std_io");
        applyStimulus(16'hE000, 1'b0, 8'h00, expVec(8'h00, 8'h00, 8'h33, SEL_KERNAL), "std_kernal");
        applyStimulus(16'h0001, 1'b0, 8'h00, expVec(8'h00, 8'h00, 8'hFF, SEL_NONE),   "std_port");

        applyStimulus(16'h0000, 1'b1, 8'h07, expVec(8'h00, 8'h00, 8'h00, SEL_RAMWE), "wr_ddr07");
        applyStimulus(16'h0001, 1'b1, 8'h05, expVec(8'h07, 8'h00, 8'hF8, SEL_RAMWE), "wr_pd05");
        applyStimulus(16'hA000, 1'b0, 8'h00, expVec(8'h07, 8'h05, 8'h11, SEL_NONE),  "m5_a000_ram");
        applyStimulus(16'hE000, 1'b0, 8'h00, expVec(8'h07, 8'h05, 8'h11, SEL_NONE),  "m5_e000_ram");
        applyStimulus(16'hD000, 1'b0, 8'h00, expVec(8'h07, 8'h05, 8'h55, SEL_IO),    "m5_d000_io");
        applyStimulus(16'h0001, 1'b1, 8'h00, expVec(8'h07, 8'h05, 8'hFD, SEL_RAMWE), "wr_pd00");
        applyStimulus(16'hD000, 1'b0, 8'h00, expVec(8'h07, 8'h00, 8'h11, SEL_NONE),  "m0_d000_ram");
        applyStimulus(16'h0001, 1'b1, 8'h03, expVec(8'h07, 8'h00, 8'hF8, SEL_RAMWE), "wr_pd03");
        applyStimulus(16'hD000, 1'b0, 8'h00, expVec(8'h07, 8'h03, 8'h44, SEL_CHAR),  "m3_d000_char");

        applyStimulus(16'h0000, 1'b1, 8'h01, expVec(8'h07, 8'h03, 8'h07, SEL_RAMWE), "wr_ddr01");
        applyStimulus(16'h0001, 1'b1, 8'h00, expVec(8'h01, 8'h03, 8'hFF, SEL_RAMWE), "wr_pd00_b");
        applyStimulus(16'h0001, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'hFE, SEL_NONE),  "eff_fe");
        applyStimulus(16'hA000, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'h11, SEL_NONE),  "lo0_basic_off");

        applyStimulus(16'h0001, 1'b1, 8'h01, expVec(8'h01, 8'h00, 8'hFE, SEL_RAMWE), "wr_pd01");
        applyStimulus(16'hA000, 1'b0, 8'h00, expVec(8'h01, 8'h01, 8'h22, SEL_BASIC), "lo1_basic_on");
        applyStimulus(16'hA123, 1'b1, 8'h5A, expVec(8'h01, 8'h01, 8'h22, SEL_RAMWE), "basic_wr_thru");
        applyStimulus(16'h0001, 1'b1, 8'h00, expVec(8'h01, 8'h01, 8'hFF, SEL_RAMWE), "wr_pd00_c");
        applyStimulus(16'hA123, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'h5A, SEL_NONE),  "ram_under_basic");

        io_rdata = 8'h0E;
        applyStimulus(16'hD020, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'h0E, SEL_IO),    "io_d020");
        applyStimulus(16'hDE00, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'h0E, SEL_NONE),  "openbus_rd");
        applyStimulus(16'hDF00, 1'b1, 8'h77, expVec(8'h01, 8'h00, 8'h0E, SEL_NONE),  "openbus_wr_drop");
        applyStimulus(16'hDE00, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'h77, SEL_NONE),  "openbus_after_wr");
        applyStimulus(16'hD020, 1'b1, 8'h12, expVec(8'h01, 8'h00, 8'h0E, SEL_IOWE),  "io_write");
        applyStimulus(16'hFFFF, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'h33, SEL_KERNAL), "kernal_ffff");
        applyStimulus(16'h9FFF, 1'b0, 8'h00, expVec(8'h01, 8'h00, 8'h11, SEL_NONE),  "ram_9fff");

        applyStimulus(16'h0000, 1'b1, 8'hFF, expVec(8'h01, 8'h00, 8'h01, SEL_RAMWE), "wr_ddrff");
        applyStimulus(16'h0001, 1'b0, 8'h00, expVec(8'hFF, 8'h00, 8'h00, SEL_NONE),  "ddrff_eff");

        // Reset asserted partway through a cycle must clear the port before the next edge
        @(posedge clk);
        #1;
        ab = 16'h0000;
        we = 1'b0;
        #2;
        reset = 1'b0;
        exp_q.push_back(expVec(8'h00, 8'h00, 8'h00, SEL_NONE));
        tag_q.push_back("midcycle_reset");
        @(negedge clk);
        checkOutput();

        applyStimulus(16'hE000, 1'b0, 8'h00, expVec(8'h00, 8'h00, 8'h33, SEL_KERNAL), "reset_kernal");
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
